// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_CPU  = 2'b01,
        GNT_DBG  = 2'b10
    } gnt_t;

    // Wait-state counter width; never narrower than one bit so WAIT_CYCLES=0 still builds.
    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker with the last-tie-winner flop.
// The lock input forces debug-only grants and freezes the round-robin history.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       dbg_req,
    input  logic       update,
    input  logic       lock,
    output logic [1:0] winner
);

    logic last_dbg;

    // Pick the winner; on a tie the loser of the previous tie goes first.
    always_comb begin
        winner = GNT_NONE;
        if (lock) begin
            if (dbg_req) begin
                winner = GNT_DBG;
            end
        end else if (cpu_req && dbg_req) begin
            winner = last_dbg ? GNT_CPU : GNT_DBG;
        end else if (cpu_req) begin
            winner = GNT_CPU;
        end else if (dbg_req) begin
            winner = GNT_DBG;
        end
    end

    // Remember who won the last tie; reset to debug so the CPU wins the first one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_dbg <= 1'b1;
        end else if (update && cpu_req && dbg_req && !lock) begin
            last_dbg <= (winner == GNT_DBG);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and debug accesses onto the single unified memory and
// inserts read wait states. Optional debug lock: define MEM_ARB_LOCK_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic          dbg_lock,
`endif
    output logic [1:0]    gnt
);

    localparam int            CW      = cnt_width(WAIT_CYCLES);
    localparam logic [CW-1:0] RD_LOAD = CW'(WAIT_CYCLES);

    arb_state_t    state;
    arb_state_t    state_nxt;
    gnt_t          owner;
    logic          we_q;
    logic [CW-1:0] cnt;
    logic [1:0]    winner;
    logic          lock;
    logic          grant;
    logic          last_cycle;

`ifdef MEM_ARB_LOCK_EN
    assign lock = dbg_lock;
`else
    assign lock = 1'b0;
`endif

    assign grant      = (state == IDLE) && (winner != GNT_NONE);
    assign last_cycle = (state == ACCESS) && (cnt == '0);

    mem_arb_rr u_rr (
        .clk     (clk),
        .reset   (reset),
        .cpu_req (cpu_req),
        .dbg_req (dbg_req),
        .update  (state == IDLE),
        .lock    (lock),
        .winner  (winner)
    );

    // State register; reset aborts any in-flight access without a ready pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and Moore outputs.
    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        cpu_ready = 1'b0;
        dbg_ready = 1'b0;
        gnt       = GNT_NONE;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                mem_we = we_q;
                gnt    = owner;
                if (cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                gnt       = owner;
                cpu_ready = (owner == GNT_CPU);
                dbg_ready = (owner == GNT_DBG);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the granted request, count wait states, capture read data for the owner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner     <= GNT_NONE;
            we_q      <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            if (grant) begin
                owner <= gnt_t'(winner);
                if (winner == GNT_DBG) begin
                    we_q      <= dbg_we;
                    mem_addr  <= dbg_addr;
                    mem_wdata <= dbg_wdata;
                    cnt       <= dbg_we ? '0 : RD_LOAD;
                end else begin
                    we_q      <= cpu_we;
                    mem_addr  <= cpu_addr;
                    mem_wdata <= cpu_wdata;
                    cnt       <= cpu_we ? '0 : RD_LOAD;
                end
            end else if ((state == ACCESS) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end
            if (last_cycle) begin
                if (owner == GNT_CPU) begin
                    cpu_rdata <= we_q ? '0 : mem_rdata;
                end else if (owner == GNT_DBG) begin
                    dbg_rdata <= we_q ? '0 : mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
// Lock scenario is built only when MEM_ARB_LOCK_EN is defined.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int WAIT = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ready;
    logic          dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_ready;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          dbg_lock = 1'b0;
    logic [1:0]    gnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(WAIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata),
        .dbg_ready (dbg_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
`ifdef MEM_ARB_LOCK_EN
        .dbg_lock  (dbg_lock),
`endif
        .gnt       (gnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m_left: access cycles still to run; m_resp: in the response cycle.
    int            m_left;
    bit            m_resp;
    int            m_owner;       // 0 none, 1 cpu, 2 dbg
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_cpu_rd, m_dbg_rd;
    bit            m_last_dbg;

    task automatic model_reset();
        m_left = 0; m_resp = 0; m_owner = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_dbg_rd = '0;
        m_last_dbg = 1'b1;
    endtask

    task automatic model_step();
        int w;
        if (m_left > 0) begin
            if (m_left == 1) begin
                m_resp = 1;
                if (m_owner == 1) m_cpu_rd = m_we ? '0 : mem_rdata;
                else              m_dbg_rd = m_we ? '0 : mem_rdata;
            end
            m_left--;
        end else if (m_resp) begin
            m_resp = 0;
        end else begin
            w = 0;
            if (dbg_lock) begin
                if (dbg_req) w = 2;
            end else if (cpu_req && dbg_req) begin
                w = m_last_dbg ? 1 : 2;
                m_last_dbg = (w == 2);
            end else if (cpu_req) w = 1;
            else if (dbg_req) w = 2;
            if (w != 0) begin
                m_owner = w;
                m_we    = (w == 1) ? cpu_we : dbg_we;
                m_addr  = (w == 1) ? cpu_addr : dbg_addr;
                m_wdata = (w == 1) ? cpu_wdata : dbg_wdata;
                m_left  = m_we ? 1 : WAIT + 1;
            end
        end
    endtask

    // Compare every cycle at the falling edge, then advance the model.
    always @(negedge clk) begin
        bit acc;
        if (!reset) model_reset();
        acc = (m_left > 0);
        chk("gnt",       gnt,       (acc || m_resp) ? m_owner : 0);
        chk("mem_en",    mem_en,    acc);
        chk("mem_we",    mem_we,    acc && m_we);
        chk("mem_addr",  mem_addr,  m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("cpu_ready", cpu_ready, m_resp && m_owner == 1);
        chk("dbg_ready", dbg_ready, m_resp && m_owner == 2);
        chk("cpu_rdata", cpu_rdata, m_cpu_rd);
        chk("dbg_rdata", dbg_rdata, m_dbg_rd);
        if (reset) model_step();
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Single access on one port; reports the cycle of ready relative to issue.
    task automatic single(input bit is_dbg, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                          output int rdy_k, output int en_n, output int we_n, output bit other);
        mem_rdata = rd;
        rdy_k = -1; en_n = 0; we_n = 0; other = 0;
        if (is_dbg) begin dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd; end
        else        begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
        for (int k = 1; k <= 12 && rdy_k < 0; k++) begin
            tick();
            if (mem_en) en_n++;
            if (mem_we) we_n++;
            if (is_dbg ? cpu_ready : dbg_ready) other = 1;
            if (is_dbg ? dbg_ready : cpu_ready) begin
                rdy_k = k;
                if (is_dbg) dbg_req = 0; else cpu_req = 0;
            end
        end
        if (rdy_k < 0) begin
            cpu_req = 0; dbg_req = 0;
        end
    endtask

    initial begin
        int  rk, en, wn, n, cpu_left;
        bit  oth, cp, dp, overlap;
        int  seq[3];

        #1 reset = 1'b0;
        // 1: reset then quiet idle
        tick(); tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_quiet", {gnt, mem_en, mem_we, cpu_ready, dbg_ready}, 6'd0);
            chk("idle_regs", mem_addr | mem_wdata | cpu_rdata | dbg_rdata, 0);
        end

        // 2: CPU read with one wait state
        single(0, 0, 32'h10, 32'h0, 32'hDEADBEEF, rk, en, wn, oth);
        chk("rd_ready_cycle", rk, 2 + WAIT);
        chk("rd_en_cycles", en, WAIT + 1);
        chk("rd_we_cycles", wn, 0);
        chk("rd_data", cpu_rdata, 32'hDEADBEEF);
        chk("rd_other_ready", oth, 0);
        tick();

        // 4: debug write
        single(1, 1, 32'h20, 32'h12345678, 32'hCAFEF00D, rk, en, wn, oth);
        chk("wr_ready_cycle", rk, 2);
        chk("wr_we_cycles", wn, 1);
        chk("wr_en_cycles", en, 1);
        chk("wr_other_ready", oth, 0);
        chk("wr_addr", mem_addr, 32'h20);
        chk("wr_wdata", mem_wdata, 32'h12345678);
        chk("wr_rdata_zero", dbg_rdata, 0);
        chk("wr_cpu_rdata_held", cpu_rdata, 32'hDEADBEEF);
        tick();

        // 3: simultaneous reads, CPU re-issues once
        mem_rdata = 32'hA5A5_0001;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h200;
        n = 0; cpu_left = 2; overlap = 0;
        for (int k = 0; k < 40 && n < 3; k++) begin
            tick();
            if (cpu_ready && dbg_ready) overlap = 1;
            if (cpu_ready) begin
                seq[n] = 1; n++;
                cpu_left--;
                if (cpu_left == 0) cpu_req = 0;
            end else if (dbg_ready) begin
                seq[n] = 2; n++;
                dbg_req = 0;
            end
        end
        chk("rr_count", n, 3);
        chk("rr_first_cpu", seq[0], 1);
        chk("rr_second_dbg", seq[1], 2);
        chk("rr_third_cpu", seq[2], 1);
        chk("rr_overlap", overlap, 0);
        cpu_req = 0; dbg_req = 0;
        tick(); tick();

        // 5: reset during a read's ACCESS, then re-issue
        mem_rdata = 32'h0BAD_F00D;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        tick();
        chk("abort_in_access", mem_en, 1);
        reset = 1'b0;
        #1;
        chk("abort_gnt", gnt, 0);
        chk("abort_en", mem_en, 0);
        chk("abort_ready", cpu_ready, 0);
        chk("abort_rdata", cpu_rdata, 0);
        tick(); tick();
        reset = 1'b1;
        rk = -1;
        for (int k = 1; k <= 12 && rk < 0; k++) begin
            tick();
            if (cpu_ready) begin rk = k; cpu_req = 0; end
        end
        cpu_req = 0;
        chk("reissue_ready_cycle", rk, 2 + WAIT);
        chk("reissue_data", cpu_rdata, 32'h0BAD_F00D);
        tick();

`ifdef MEM_ARB_LOCK_EN
        // 6: debug lock starves the CPU
        dbg_lock = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h300;
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h400; dbg_wdata = 32'h1;
        n = 0;
        for (int k = 0; k < 30 && n < 3; k++) begin
            tick();
            chk("lock_no_cpu", gnt == 2'b01, 0);
            if (dbg_ready) begin
                n++;
                if (n == 3) begin dbg_req = 0; dbg_lock = 0; end
            end
        end
        chk("lock_dbg_count", n, 3);
        tick();
        tick();
        chk("unlock_cpu_gnt", gnt, 2'b01);
        rk = -1;
        for (int k = 0; k < 12 && rk < 0; k++) begin
            tick();
            if (cpu_ready) begin rk = k; cpu_req = 0; end
        end
        cpu_req = 0;
        chk("unlock_cpu_done", rk >= 0, 1);
        tick();
`endif

        // Randomized traffic
        cp = 0; dp = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            mem_rdata = $urandom;
            if (c == 1500) reset = 1'b0;
            if (c == 1502) reset = 1'b1;
            if (cpu_ready) begin cp = 0; cpu_req = 0; end
            if (dbg_ready) begin dp = 0; dbg_req = 0; end
            if (!cp && $urandom_range(0, 2) == 0) begin
                cp = 1; cpu_req = 1; cpu_we = 1'($urandom);
                cpu_addr = $urandom; cpu_wdata = $urandom;
            end else if (cp && gnt == 2'b01 && !cpu_ready && $urandom_range(0, 15) == 0) begin
                cp = 0; cpu_req = 0;
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1; dbg_req = 1; dbg_we = 1'($urandom);
                dbg_addr = $urandom; dbg_wdata = $urandom;
            end else if (dp && gnt == 2'b10 && !dbg_ready && $urandom_range(0, 15) == 0) begin
                dp = 0; dbg_req = 0;
            end
        end
        cpu_req = 0; dbg_req = 0;
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
